bcd_ascii_tx: RTL and testbench
===============================

// Module: bcd_ascii_tx
// PURPOSE
//  Downstream consumer of the 8-bit binary-to-BCD converter output (3 BCD digits).
//  Takes one 12-bit BCD value per handshake and turns it into an ASCII decimal line.
//  Emits the line one byte at a time to the UART transmitter over valid/ready.
//  Line format: digits, then CR LF. Example: a decoded NEC byte 0xFF prints as "255\r\n".
// PARAMETERS
//  SUPPRESS_ZEROS  1  1: drop leading zero digits (units always sent); 0: always send 3 digits
//  EOL_CRLF        1  1: terminate with CR (0x0D) then LF (0x0A); 0: LF only
// PORTS
//  clk        in   1   single clock; all logic on rising edge
//  rst_n      in   1   reset; synchronous, active-low
//  bcd_valid  in   1   bcd holds a value to print
//  bcd        in   12  {hundreds[11:8], tens[7:4], units[3:0]}
//  bcd_ready  out  1   block idle; accepts bcd this cycle if bcd_valid
//  tx_data    out  8   ASCII byte to UART TX
//  tx_valid   out  1   tx_data valid
//  tx_ready   in   1   UART TX accepts tx_data this cycle
//  busy       out  1   a line is being emitted (state != IDLE)
// BEHAVIOUR
//  Reset (rst_n low at clk edge): state=IDLE, tx_valid=0, tx_data=8'h00, busy=0, bcd_ready=0.
//   First edge with rst_n high: bcd_ready=1. Registered outputs only.
//  FSM states: IDLE, HUND, TENS, UNITS, CR, LF.
//  IDLE: bcd_ready=1. On bcd_valid&&bcd_ready, register bcd. Choose first state:
//   HUND if !SUPPRESS_ZEROS or h!=0. Else TENS if t!=0. Else UNITS.
//   Next edge: bcd_ready=0, busy=1, tx_valid=1, tx_data=first byte. Latency accept->tx_valid is 1 cycle.
//  Digit byte = 8'h30 + nibble for nibble<=9. Nibble>9 (invalid BCD) sends 8'h3F '?'.
//   A nibble >9 counts as nonzero for suppression.
//  Byte transfer = tx_valid&&tx_ready at an edge. On transfer, advance:
//   HUND->TENS->UNITS->(CR if EOL_CRLF else LF)->LF->IDLE.
//   Next byte is presented on the same edge, so with tx_ready=1 continuously there is
//   one byte per cycle with no bubbles.
//  Backpressure: while tx_valid&&!tx_ready, tx_data and state are held stable.
//   tx_valid never drops before its transfer.
//  After the LF transfer edge: tx_valid=0, busy=0, bcd_ready=1.
//   A new bcd is accepted no earlier than the following edge, so frames never overlap.
//   The minimum gap is 1 idle cycle.
//  bcd_valid while busy is ignored (bcd_ready=0). Upstream holds its value. bcd is never re-sampled mid-line.
//  tx_ready while tx_valid=0 is ignored.
//  Reset mid-line: the line is abandoned, with no partial continuation.
//   tx_valid=0 from the first reset edge. Restart from IDLE.
// TESTING
//  1 bcd=12'h255, tx_ready=1 -> tx_valid the cycle after accept.
//    Bytes 32,35,35,0D,0A on 5 consecutive edges, then bcd_ready=1.
//  2 SUPPRESS_ZEROS=1: bcd=12'h007 -> 37,0D,0A; bcd=12'h000 -> 30,0D,0A; bcd=12'h040 -> 34,30,0D,0A.
//    SUPPRESS_ZEROS=0: bcd=12'h007 -> 30,30,37,0D,0A.
//  3 bcd=12'h128, tx_ready random 30% -> exactly 31,32,38,0D,0A.
//    tx_data stable whenever tx_valid&&!tx_ready. No loss or duplication.
//  4 bcd=12'h0A5 (invalid tens) -> 3F,35,0D,0A. With EOL_CRLF=0, bcd=12'h099 -> 39,39,0A.
//  5 bcd=12'h255, assert rst_n=0 after 2 bytes transfer -> tx_valid=0 at that edge.
//    After release, bcd=12'h001 -> 31,0D,0A only.
//  6 Hold bcd_valid high with 12'h100 then 12'h200 back-to-back.
//    -> both lines emitted in order, never interleaved, bcd_ready low throughout each line.

Source files
------------

// File: rtl/bcd_ascii_tx.sv
// bcd_ascii_tx: turns one 3-digit BCD value per handshake into an ASCII
// decimal line ("255\r\n") and streams it byte by byte to a UART transmitter.
//
// Handshakes: on both interfaces a transfer happens at a rising edge where
// valid and ready are both high. The producer holds valid and its data stable
// until that edge. bcd_ready is high only in IDLE, so a value is sampled at
// most once per line. tx_valid, once raised, stays high with tx_data frozen
// until the byte is taken. The following byte is presented on that same edge.
module bcd_ascii_tx #(
  parameter bit SUPPRESS_ZEROS = 1'b1,
  parameter bit EOL_CRLF       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bcd_valid,
  input  logic [11:0] bcd,
  output logic        bcd_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HUND  = 3'd1,
    TENS  = 3'd2,
    UNITS = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  state_t      first_state;
  logic [11:0] bcd_q, bcd_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        bcd_ready_q, bcd_ready_d;

  // Non-decimal nibbles print as '?' so corrupted input stays visible.
  function automatic logic [7:0] digit_ascii(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
    else           return 8'h3F;
  endfunction

  // Byte shown while sitting in state s for the value v.
  function automatic logic [7:0] byte_for(input state_t s, input logic [11:0] v);
    case (s)
      HUND:    return digit_ascii(v[11:8]);
      TENS:    return digit_ascii(v[7:4]);
      UNITS:   return digit_ascii(v[3:0]);
      CR:      return 8'h0D;
      LF:      return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

  // Sequence of line positions; the CR step is skipped for LF-only endings.
  function automatic state_t after(input state_t s);
    case (s)
      HUND:    return TENS;
      TENS:    return UNITS;
      UNITS:   return EOL_CRLF ? CR : LF;
      CR:      return LF;
      default: return IDLE;
    endcase
  endfunction

  // First digit to print: leading zeros dropped when suppressing, units always kept.
  always_comb begin
    first_state = UNITS;
    if (!SUPPRESS_ZEROS || (bcd[11:8] != 4'd0)) first_state = HUND;
    else if (bcd[7:4] != 4'd0)                  first_state = TENS;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    busy_d      = busy_q;
    bcd_ready_d = bcd_ready_q;
    case (state_q)
      IDLE: begin
        bcd_ready_d = 1'b1;
        busy_d      = 1'b0;
        tx_valid_d  = 1'b0;
        if (bcd_valid && bcd_ready_q) begin
          bcd_d       = bcd;
          state_d     = first_state;
          tx_data_d   = byte_for(first_state, bcd);
          tx_valid_d  = 1'b1;
          busy_d      = 1'b1;
          bcd_ready_d = 1'b0;
        end
      end
      default: begin
        if (tx_valid_q && tx_ready) begin
          state_d = after(state_q);
          if (state_d == IDLE) begin
            tx_valid_d  = 1'b0;
            busy_d      = 1'b0;
            bcd_ready_d = 1'b1;
          end else begin
            tx_data_d = byte_for(state_d, bcd_q);
          end
        end
      end
    endcase
  end

  // State and output registers; reset abandons any line in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bcd_q       <= 12'h000;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      bcd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      bcd_ready_q <= bcd_ready_d;
    end
  end

  assign bcd_ready = bcd_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_ascii_tx.sv
// Bench for bcd_ascii_tx: three instances cover the parameter variants
// (0: defaults, 1: no zero suppression, 2: LF-only endings).
module tb_bcd_ascii_tx;

  logic        clk;
  logic        rst_n;
  logic        bcd_valid [3];
  logic [11:0] bcd       [3];
  logic        bcd_ready [3];
  logic [7:0]  tx_data   [3];
  logic        tx_valid  [3];
  logic        tx_ready  [3];
  logic        busy      [3];

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  typedef struct {
    int          k;
    logic [11:0] value;
    int          pct;
    int          n;
    logic [7:0]  b [5];
    string       name;
  } vec_t;

  vec_t vecs [11];

  bcd_ascii_tx #(.SUPPRESS_ZEROS(1'b1), .EOL_CRLF(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bcd_valid(bcd_valid[0]), .bcd(bcd[0]),
    .bcd_ready(bcd_ready[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .busy(busy[0]));

  bcd_ascii_tx #(.SUPPRESS_ZEROS(1'b0), .EOL_CRLF(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bcd_valid(bcd_valid[1]), .bcd(bcd[1]),
    .bcd_ready(bcd_ready[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .busy(busy[1]));

  bcd_ascii_tx #(.SUPPRESS_ZEROS(1'b1), .EOL_CRLF(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bcd_valid(bcd_valid[2]), .bcd(bcd[2]),
    .bcd_ready(bcd_ready[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .busy(busy[2]));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int k, input logic [11:0] value, input int pct,
                         input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                         input string name);
    vecs[i].k = k; vecs[i].value = value; vecs[i].pct = pct; vecs[i].n = n;
    vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2;
    vecs[i].b[3] = b3; vecs[i].b[4] = b4; vecs[i].name = name;
  endtask

  // Send one value and check every byte of the resulting line.
  task automatic run_line(input vec_t v);
    int cyc;
    logic stalled;
    logic [7:0] held;
    logic [7:0] want;
    int k;
    k = v.k;
    held = 8'h00;
    for (int i = 0; i < v.n; i++) exp_q.push_back(v.b[i]);
    @(negedge clk);
    bcd[k] = v.value;
    bcd_valid[k] = 1'b1;
    cyc = 0;
    while (!bcd_ready[k] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!bcd_ready[k]) begin
      check({v.name, "_accept_timeout"}, 32'(bcd_ready[k]), 32'd1);
      bcd_valid[k] = 1'b0;
      exp_q.delete();
      return;
    end
    @(negedge clk);
    bcd_valid[k] = 1'b0;
    check({v.name, "_first_valid"}, 32'(tx_valid[k]), 32'd1);
    check({v.name, "_busy"}, 32'(busy[k]), 32'd1);
    check({v.name, "_ready_low"}, 32'(bcd_ready[k]), 32'd0);
    stalled = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      check({v.name, "_valid_held"}, 32'(tx_valid[k]), 32'd1);
      check({v.name, "_ready_low_line"}, 32'(bcd_ready[k]), 32'd0);
      if (stalled) check({v.name, "_data_stable"}, 32'(tx_data[k]), 32'(held));
      tx_ready[k] = ($urandom_range(0, 99) < v.pct);
      if (tx_valid[k] && tx_ready[k]) begin
        want = exp_q.pop_front();
        check({v.name, "_byte"}, 32'(tx_data[k]), 32'(want));
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = tx_data[k];
      end
      @(negedge clk);
      cyc++;
    end
    tx_ready[k] = 1'b1;
    if (exp_q.size() > 0) begin
      check({v.name, "_line_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    check({v.name, "_end_valid"}, 32'(tx_valid[k]), 32'd0);
    check({v.name, "_end_busy"}, 32'(busy[k]), 32'd0);
    check({v.name, "_end_ready"}, 32'(bcd_ready[k]), 32'd1);
  endtask

  initial begin
    int accepts;
    int cyc;
    logic accept_now;
    logic [7:0] want;
    vec_t v;
    checks = 0;
    failures = 0;

    set_vec(0,  0, 12'h255, 100, 5, 8'h32, 8'h35, 8'h35, 8'h0D, 8'h0A, "v255");
    set_vec(1,  0, 12'h007, 100, 3, 8'h37, 8'h0D, 8'h0A, 8'h00, 8'h00, "v007");
    set_vec(2,  0, 12'h000, 100, 3, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, "v000");
    set_vec(3,  0, 12'h040, 100, 4, 8'h34, 8'h30, 8'h0D, 8'h0A, 8'h00, "v040");
    set_vec(4,  1, 12'h007, 100, 5, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A, "nz007");
    set_vec(5,  0, 12'h128, 30,  5, 8'h31, 8'h32, 8'h38, 8'h0D, 8'h0A, "bp128");
    set_vec(6,  0, 12'h0A5, 100, 4, 8'h3F, 8'h35, 8'h0D, 8'h0A, 8'h00, "v0A5");
    set_vec(7,  2, 12'h099, 100, 3, 8'h39, 8'h39, 8'h0A, 8'h00, 8'h00, "lf099");
    set_vec(8,  1, 12'h0A5, 100, 5, 8'h30, 8'h3F, 8'h35, 8'h0D, 8'h0A, "nz0A5");
    set_vec(9,  2, 12'h100, 50,  4, 8'h31, 8'h30, 8'h30, 8'h0A, 8'h00, "lf100");
    set_vec(10, 0, 12'hF00, 100, 5, 8'h3F, 8'h30, 8'h30, 8'h0D, 8'h0A, "vF00");

    // Reset
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bcd_valid[k] = 1'b0;
      bcd[k] = 12'h000;
      tx_ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_tx_valid", 32'(tx_valid[k]), 32'd0);
      check("rst_tx_data", 32'(tx_data[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_bcd_ready", 32'(bcd_ready[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("post_rst_ready", 32'(bcd_ready[k]), 32'd1);

    // Table of single lines
    for (int i = 0; i < 11; i++) run_line(vecs[i]);

    // Reset in the middle of a line
    @(negedge clk);
    bcd[0] = 12'h255;
    bcd_valid[0] = 1'b1;
    tx_ready[0] = 1'b1;
    @(negedge clk);
    bcd_valid[0] = 1'b0;
    check("mid_byte0", 32'(tx_data[0]), 32'h32);
    @(negedge clk);
    check("mid_byte1", 32'(tx_data[0]), 32'h35);
    @(negedge clk);
    check("mid_byte2_shown", 32'(tx_valid[0]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(tx_valid[0]), 32'd0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_data", 32'(tx_data[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(bcd_ready[0]), 32'd1);
    v.k = 0; v.value = 12'h001; v.pct = 100; v.n = 3;
    v.b[0] = 8'h31; v.b[1] = 8'h0D; v.b[2] = 8'h0A; v.b[3] = 8'h00; v.b[4] = 8'h00;
    v.name = "after_rst001";
    run_line(v);

    // Back-to-back lines with bcd_valid held high
    exp_q = '{8'h31, 8'h30, 8'h30, 8'h0D, 8'h0A, 8'h32, 8'h30, 8'h30, 8'h0D, 8'h0A};
    @(negedge clk);
    bcd[0] = 12'h100;
    bcd_valid[0] = 1'b1;
    tx_ready[0] = 1'b1;
    accepts = 0;
    cyc = 0;
    while ((exp_q.size() > 0 || accepts < 2) && cyc < 60) begin
      accept_now = bcd_valid[0] && bcd_ready[0];
      if (busy[0]) check("b2b_ready_low", 32'(bcd_ready[0]), 32'd0);
      if (tx_valid[0] && tx_ready[0]) begin
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          check("b2b_byte", 32'(tx_data[0]), 32'(want));
        end else begin
          check("b2b_extra_byte", 32'(tx_valid[0]), 32'd0);
        end
      end
      @(negedge clk);
      cyc++;
      if (accept_now) begin
        accepts++;
        if (accepts == 1) bcd[0] = 12'h200;
        else bcd_valid[0] = 1'b0;
      end
    end
    bcd_valid[0] = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd2);
    check("b2b_remaining", 32'(exp_q.size()), 32'd0);
    check("b2b_end_valid", 32'(tx_valid[0]), 32'd0);
    check("b2b_end_ready", 32'(bcd_ready[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
